piso_tx: RTL
============

# piso_tx

Parallel-in, serial-out transmitter that drives a single registered data line, one bit per clock. It accepts a WIDTH-bit word over a valid/ready handshake and emits it as a framed bit stream. The stream is `ser_out`, qualified by `ser_valid` and marked by `frame_start`. It is the sending end of the single-bit data path consumed by our flip-flop and shift-register capture blocks, so those blocks get real framed traffic instead of hand-toggled `d` stimulus.

## Interface
- `WIDTH`, 8, word length in bits; legal range 2..32.
- `MSB_FIRST`, 1, bit order. 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `load_valid`  input  1  `load_data` is offered.
- `load_ready`  output  1  block can accept a word this cycle.
- `load_data`  input  WIDTH  word to transmit; sampled only on accept.
- `ser_out`  output  1  serial data bit, registered.
- `ser_valid`  output  1  `ser_out` carries a frame bit this cycle, registered.
- `frame_start`  output  1  high on the first bit of each frame, registered.
- `busy`  output  1  a frame is being shifted out, registered.

## Operation
- **States.**
  - IDLE: no frame in flight.
  - SHIFT: frame in flight; a bit counter `cnt` runs 0..WIDTH-1.
- **Accept.** A word is accepted when `load_valid && load_ready` is true at a rising edge.
- **`load_ready`.** Defined as `!rst && (state==IDLE || (state==SHIFT && cnt==WIDTH-1))`.
  - It is combinational from registered state and `rst` only.
  - It never depends on `load_valid`.
- **IDLE → SHIFT.** On accept:
  - The word goes into the shift register.
  - `cnt` is set to 0.
  - The first bit is driven.
- **SHIFT, cnt < WIDTH-1.** Each cycle the register shifts toward the output end and `cnt` increments.
- **SHIFT, cnt == WIDTH-1 (last bit).**
  - With an accept: reload the register, set `cnt` to 0, stay in SHIFT. Frames run back-to-back with no gap cycle.
  - Without an accept: go to IDLE.
- **Outputs.**
  - `busy` = (state==SHIFT).
  - `ser_valid` = `busy`.
  - `frame_start` is high only while `cnt`==0 in SHIFT.
  - In IDLE, `ser_out` is 0.
- **Holding `load_data`.** `load_data` is ignored when there is no accept. The captured word is not affected by later changes on the input.
- **Width rule.** `cnt` is $clog2(WIDTH) bits wide. Comparisons use WIDTH-1 at that width.
- **Reset.** While `rst` is high at an edge:
  - state → IDLE, `cnt` → 0, shift register → 0.
  - Any `load_valid` in that cycle is not accepted; `load_ready` is 0.
- **Reset mid-frame.** The frame is aborted.
  - In the cycle after the reset edge, `ser_valid`, `frame_start` and `busy` are 0.
  - No partial remainder is sent later.

## Timing
- **Reset values.** After the reset edge, all outputs are 0: `ser_out`, `ser_valid`, `frame_start`, `busy`. `load_ready` is 0 during reset and 1 in the first cycle after it.
- **Latency.** Accept at edge N puts the first bit on `ser_out` with `ser_valid`=1 and `frame_start`=1 from edge N to edge N+1.
- **Frame length.** Bit k of the frame is valid between edges N+k and N+k+1. A frame occupies exactly WIDTH cycles.
- **Back-to-back.** With `load_valid` held high, throughput is one bit per cycle continuously, and `frame_start` pulses every WIDTH cycles.
- **`load_ready` tracking.** `load_ready` rises in the same cycle that the last bit is on `ser_out`.

## Structure
- **Shared package `piso_pkg`:**
  - state enum `{ST_IDLE, ST_SHIFT}`.
  - localparam helper for the counter width.
- **Sub-module `bit_counter`:** parameterised modulo counter with load-to-zero and terminal-count output.
- **Top level holds:** FSM, shift register, output registers.

## Test plan
- **Single word, MSB first.** WIDTH=8, MSB_FIRST=1, load 8'hA5 after reset → `ser_out` = 1,0,1,0,0,1,0,1 over 8 cycles. `frame_start` is high only on the first bit. `busy` drops after bit 7.
- **LSB first.** MSB_FIRST=0, load 8'h01 → `ser_out` = 1,0,0,0,0,0,0,0.
- **Back-to-back.** `load_valid` held high with 8'hF0 then 8'h0F → 16 contiguous valid bits 11110000 00001111. `frame_start` at cycles 0 and 8. No idle cycle between frames.
- **Handshake.**
  - `load_valid` asserted at bit 3 of a frame → not accepted.
  - `load_ready` is 0 until bit 7 and is then accepted.
  - Changing `load_data` mid-frame does not alter the bits being sent.
- **Reset mid-frame.** Reset asserted during bit 4 of 8'hFF → in the next cycle all outputs are 0 and `load_ready`=0 while `rst` is high. After release, `load_ready`=1 and a new word 8'h81 transmits cleanly.
- **Reset with a load.** `rst`=1 and `load_valid`=1 at the same edge → no frame starts; `busy` stays 0.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and counter sizing for the serial transmitter
package piso_pkg;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return (w < MIN_WIDTH) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// piso_tx_if: load handshake and framed serial stream of the transmitter
interface piso_tx_if
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output load_valid, load_data,
        input  load_ready, ser_out, ser_valid, frame_start, busy
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, ser_out, ser_valid, frame_start, busy
    );

endinterface

// File: rtl/piso_tx_bit_counter.sv
// bit_counter: modulo-MOD counter with clear-to-zero and terminal-count flag
module bit_counter
    import piso_pkg::*;
#(
    parameter int MOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_width(MOD);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = cnt_q == CW'(MOD - 1);

    // clear wins over counting; wrap to zero after the terminal count
    always_comb begin
        cnt_d = (clr || (en && tc)) ? '0 : (en ? cnt_q + 1'b1 : cnt_q);
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/piso_tx.sv
// piso_tx: accepts a word over valid/ready and shifts it out one bit per clock
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input logic       clk,
    input logic       rst,
    piso_tx_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             frame_start_q, frame_start_d;
    logic             shifting, tc, accept;

    assign shifting       = state_q == ST_SHIFT;
    assign bus.load_ready = !rst && (!shifting || tc);
    assign accept         = bus.load_valid && bus.load_ready;

    bit_counter #(.MOD(WIDTH)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept || !shifting),
        .en  (shifting),
        .tc  (tc)
    );

    // next state: load on accept, otherwise shift zeros in so the line idles low
    always_comb begin
        state_d       = state_q;
        sreg_d        = '0;
        frame_start_d = accept;
        if (accept) begin
            state_d = ST_SHIFT;
            sreg_d  = bus.load_data;
        end else if (shifting) begin
            state_d = tc ? ST_IDLE : ST_SHIFT;
            sreg_d  = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    // state, shift register and frame marker
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sreg_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.ser_out     = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign bus.ser_valid   = shifting;
    assign bus.busy        = shifting;
    assign bus.frame_start = frame_start_q;

endmodule
